// File: rtl/sim_reset_sequencer_if.sv
// sim_reset_sequencer_if: lock/soft-request inputs and staged reset outputs of the reset sequencer
// Ports (signals):
//   dcm_locked     clock-source lock, asynchronous to the sequencer clock
//   soft_reset_req single-cycle request to re-run the release sequence
//   rst_stage      active-high staged resets, bit 0 released first
//   ready          high once every stage is released
//   lock_lost      sticky lock-loss flag
//   lock_loss_cnt  saturating lock-loss event count
// master drives the requests and observes the resets; slave is the sequencer.
interface sim_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  dcm_locked;
    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] rst_stage;
    logic                  ready;
    logic                  lock_lost;
    logic [7:0]            lock_loss_cnt;
    modport master (
        output dcm_locked, soft_reset_req,
        input  rst_stage, ready, lock_lost, lock_loss_cnt
    );
    modport slave (
        input  dcm_locked, soft_reset_req,
        output rst_stage, ready, lock_lost, lock_loss_cnt
    );
endinterface

// File: rtl/sim_reset_sequencer.sv
// sim_reset_sequencer: staged reset release gated by a synchronized, stable clock-source lock
// Ports:
//   clock_i  sequencer clock
//   reset_i  synchronous active-high reset, forces the full reset state
//   bus      slave side: dcm_locked/soft_reset_req in; rst_stage/ready/lock_lost/lock_loss_cnt out
module sim_reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_STABLE = 8,
    parameter int STAGE_GAP   = 4,
    parameter int SOFT_HOLD   = 16
) (
    input logic                 clock_i,
    input logic                 reset_i,
    sim_reset_sequencer_if.slave bus
);
    localparam int          IW      = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    localparam logic [15:0] LS      = 16'(LOCK_STABLE);
    localparam logic [15:0] GAP     = 16'(STAGE_GAP);
    localparam logic [15:0] HOLD    = 16'(SOFT_HOLD);
    localparam logic [IW-1:0] LAST  = IW'(NUM_STAGES - 1);
    typedef enum logic [2:0] {WAIT_LOCK, STABLE, RELEASE, RUN, SOFT_HOLD_ST} state_t;
    state_t                state_q;
    logic [1:0]            sync_q;
    logic [15:0]           cnt_q;
    logic [IW-1:0]         idx_q;
    logic [NUM_STAGES-1:0] rst_stage_q;
    logic                  ready_q;
    logic                  lock_lost_q;
    logic [7:0]            loss_cnt_q;
    logic                  lock_s;
    assign lock_s            = sync_q[1];
    assign bus.rst_stage     = rst_stage_q;
    assign bus.ready         = ready_q;
    assign bus.lock_lost     = lock_lost_q;
    assign bus.lock_loss_cnt = loss_cnt_q;
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_stage_q <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.dcm_locked};
            // lock loss only matters once stages may have been released
            if ((state_q == RELEASE || state_q == RUN) && !lock_s) begin
                rst_stage_q <= '1;
                ready_q     <= 1'b0;
                state_q     <= WAIT_LOCK;
                cnt_q       <= '0;
                if (state_q == RUN) begin
                    lock_lost_q <= 1'b1;
                    loss_cnt_q  <= loss_cnt_q == 8'hff ? loss_cnt_q : loss_cnt_q + 8'd1;
                end
            end else if (bus.soft_reset_req && state_q != SOFT_HOLD_ST) begin
                rst_stage_q <= '1;
                ready_q     <= 1'b0;
                state_q     <= SOFT_HOLD_ST;
                cnt_q       <= 16'd1;
            end else begin
                case (state_q)
                    WAIT_LOCK: if (lock_s) begin
                        state_q <= STABLE;
                        cnt_q   <= 16'd1;
                    end
                    STABLE: if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == LS) begin
                        rst_stage_q[0] <= 1'b0;
                        idx_q          <= IW'(1);
                        cnt_q          <= 16'd1;
                        state_q        <= NUM_STAGES == 1 ? RUN : RELEASE;
                        ready_q        <= NUM_STAGES == 1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    RELEASE: if (cnt_q == GAP) begin
                        rst_stage_q[idx_q] <= 1'b0;
                        idx_q              <= idx_q + IW'(1);
                        cnt_q              <= 16'd1;
                        if (idx_q == LAST) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    SOFT_HOLD_ST: if (cnt_q == HOLD) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    RUN: ;
                    default: state_q <= WAIT_LOCK;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sim_reset_sequencer.sv
// tb_sim_reset_sequencer: timestamp model of the reset sequencer plus pinned literal expectations
module tb_sim_reset_sequencer;
    localparam int N   = 3;
    localparam int LS  = 8;
    localparam int GAP = 4;
    localparam int SH  = 16;
    logic clk = 1'b1;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;
    sim_reset_sequencer_if #(.NUM_STAGES(N)) bus ();
    sim_reset_sequencer #(.NUM_STAGES(N), .LOCK_STABLE(LS), .STAGE_GAP(GAP), .SOFT_HOLD(SH)) dut (
        .clock_i(clk),
        .reset_i(rst_i),
        .bus    (bus)
    );
    int ec = 0;
    always @(posedge clk) ec <= ec + 1;
    typedef struct {
        int           e;
        logic [N-1:0] rs;
        logic         rdy;
        logic         lost;
        logic [7:0]   cnt;
    } exp_t;
    exp_t hq[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    // model: the sequence is described by the edge it started counting (m_arm) and the edge a soft hold began
    int   m_arm = -1;
    int   m_hold = -1;
    bit   m_h1 = 0;
    bit   m_h2 = 0;
    bit   m_lost = 0;
    int   m_cnt = 0;
    bit   m_valid = 0;
    function automatic int rel_at(int n);
        int r;
        if (m_arm < 0 || n - m_arm < LS) return 0;
        r = (n - m_arm - LS) / GAP + 1;
        return r > N ? N : r;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ec, act, exp);
        end
    endtask
    always @(negedge clk) begin
        int  rel;
        int  n;
        bit  ls;
        bit  was_rel;
        bit  was_run;
        if (m_valid) begin
            rel = rel_at(ec);
            chk("rst_stage", 32'(bus.rst_stage), 32'(N'(~((32'd1 << rel) - 32'd1))));
            chk("ready", 32'(bus.ready), 32'(rel == N));
            chk("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
            chk("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_cnt));
            while (hq.size() > 0 && hq[0].e <= ec) begin
                if (hq[0].e < ec) begin
                    checks++;
                    errors++;
                    $display("FAIL pin_missed: edge %0d passed, now %0d", hq[0].e, ec);
                end else begin
                    chk("pin_rst_stage", 32'(bus.rst_stage), 32'(hq[0].rs));
                    chk("pin_ready", 32'(bus.ready), 32'(hq[0].rdy));
                    chk("pin_lock_lost", 32'(bus.lock_lost), 32'(hq[0].lost));
                    chk("pin_lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(hq[0].cnt));
                end
                void'(hq.pop_front());
            end
        end
        if (done) begin
            if (hq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL pin_leftover: %0d expectations never reached, expected 0", hq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        n = ec + 1;
        ls = m_h2;
        if (rst_i) begin
            m_arm = -1;
            m_hold = -1;
            m_lost = 0;
            m_cnt = 0;
            m_h1 = 0;
            m_h2 = 0;
            m_valid = 1;
        end else begin
            m_h2 = m_h1;
            m_h1 = bus.dcm_locked;
            was_rel = m_arm >= 0 && n - m_arm > LS;
            was_run = m_arm >= 0 && rel_at(n - 1) == N;
            if (was_rel && !ls) begin
                if (was_run) begin
                    m_lost = 1;
                    m_cnt = m_cnt == 255 ? 255 : m_cnt + 1;
                end
                m_arm = -1;
            end else if (bus.soft_reset_req && m_hold < 0) begin
                m_hold = n;
                m_arm = -1;
            end else if (m_hold >= 0) begin
                if (n - m_hold == SH) m_hold = -1;
            end else if (m_arm < 0) begin
                if (ls) m_arm = n;
            end else if (!ls) begin
                m_arm = -1;
            end
        end
    end
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic to_edge(input int e);
        while (ec < e) tick(1);
    endtask
    task automatic pin(input int e, input logic [N-1:0] rs, input logic rdy, input logic lost, input logic [7:0] c);
        hq.push_back('{e, rs, rdy, lost, c});
    endtask
    initial begin
        int b;
        int d;
        int s;
        bus.dcm_locked = 1'b0;
        bus.soft_reset_req = 1'b0;
        pin(2, 3'b111, 0, 0, 0);
        tick(3);
        // lock rises with reset released: edge b is "edge 0"
        rst_i = 1'b0;
        bus.dcm_locked = 1'b1;
        b = ec + 1;
        pin(b + 9, 3'b111, 0, 0, 0);
        pin(b + 10, 3'b110, 0, 0, 0);
        pin(b + 14, 3'b100, 0, 0, 0);
        pin(b + 18, 3'b000, 1, 0, 0);
        to_edge(b + 20);
        // soft request in RUN
        s = ec + 1;
        bus.soft_reset_req = 1'b1;
        pin(s, 3'b111, 0, 0, 0);
        pin(s + 15, 3'b111, 0, 0, 0);
        pin(s + 24, 3'b111, 0, 0, 0);
        pin(s + 25, 3'b110, 0, 0, 0);
        pin(s + 33, 3'b000, 1, 0, 0);
        tick(1);
        bus.soft_reset_req = 1'b0;
        to_edge(s + 35);
        // lock drop in RUN, restored three cycles later
        d = ec;
        bus.dcm_locked = 1'b0;
        pin(d + 2, 3'b000, 1, 0, 0);
        pin(d + 3, 3'b111, 0, 1, 1);
        tick(3);
        bus.dcm_locked = 1'b1;
        pin(d + 13, 3'b111, 0, 1, 1);
        pin(d + 14, 3'b110, 0, 1, 1);
        pin(d + 22, 3'b000, 1, 1, 1);
        to_edge(d + 24);
        // reset right after stage 0 releases
        d = ec;
        bus.dcm_locked = 1'b0;
        tick(1);
        bus.dcm_locked = 1'b1;
        pin(d + 3, 3'b111, 0, 1, 2);
        pin(d + 12, 3'b110, 0, 1, 2);
        to_edge(d + 12);
        rst_i = 1'b1;
        pin(d + 13, 3'b111, 0, 0, 0);
        tick(1);
        rst_i = 1'b0;
        pin(d + 23, 3'b111, 0, 0, 0);
        pin(d + 24, 3'b110, 0, 0, 0);
        pin(d + 32, 3'b000, 1, 0, 0);
        to_edge(d + 34);
        // one-cycle lock glitch while counting stability
        d = ec;
        bus.dcm_locked = 1'b0;
        tick(1);
        bus.dcm_locked = 1'b1;
        pin(d + 3, 3'b111, 0, 1, 1);
        to_edge(d + 5);
        bus.dcm_locked = 1'b0;
        pin(d + 16, 3'b111, 0, 1, 1);
        pin(d + 17, 3'b110, 0, 1, 1);
        pin(d + 25, 3'b000, 1, 1, 1);
        tick(1);
        bus.dcm_locked = 1'b1;
        to_edge(d + 27);
        // 300 lock drops in RUN saturate the counter
        repeat (300) begin
            d = ec;
            bus.dcm_locked = 1'b0;
            tick(1);
            bus.dcm_locked = 1'b1;
            to_edge(d + 22);
        end
        pin(ec + 1, 3'b000, 1, 1, 255);
        tick(2);
        // soft request keeps lock history; a second request during the hold is ignored
        s = ec + 1;
        bus.soft_reset_req = 1'b1;
        pin(s, 3'b111, 0, 1, 255);
        tick(1);
        bus.soft_reset_req = 1'b0;
        to_edge(s + 4);
        bus.soft_reset_req = 1'b1;
        tick(1);
        bus.soft_reset_req = 1'b0;
        pin(s + 24, 3'b111, 0, 1, 255);
        pin(s + 25, 3'b110, 0, 1, 255);
        pin(s + 33, 3'b000, 1, 1, 255);
        to_edge(s + 35);
        done = 1;
        tick(3);
    end
endmodule
